fetch_stage: RTL and testbench

- Fetch stage of the 5-stage pipelined RV32I core.
- Owns the program counter (PCF) and drives a request/response instruction-memory port that tolerates variable latency.
- Also owns the IF/ID pipeline register: it obeys StallF/StallD/FlushD from the hazard unit and redirects on a taken branch/jump (PCSrcE/PCTargetE) from the execute stage.
- Delivers InstrD/PCD/PCPlus4D with a ValidD qualifier to the decode stage.

---
 rtl/fetch_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of a 5-stage pipelined RV32I core. It owns the
// program counter (PCF) and the IF/ID pipeline register, and talks to
// instruction memory over a request/response port with variable latency.
// At most one memory request is outstanding at any time.
//
// Optional feature: define FETCH_PERF_EN to add the FetchCount/KillCount
// performance counters. Without the macro those ports do not exist.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   reset_n      synchronous active-low reset
//   StallF       hazard unit: hold PCF
//   StallD       hazard unit: hold the IF/ID register
//   FlushD       hazard unit: turn the IF/ID register into a bubble
//   PCSrcE       execute stage: redirect fetch
//   PCTargetE    execute stage: redirect target address
//   imem_req     request valid (0 while reset_n is low)
//   imem_addr    request address (always PCF)
//   imem_ack     memory accepts the request this cycle
//   imem_rvalid  response data valid
//   imem_rdata   response instruction word
//   InstrD       decode-stage instruction
//   PCD          decode-stage PC
//   PCPlus4D     decode-stage PC + 4
//   ValidD       IF/ID holds a real instruction
//   FetchCount   (FETCH_PERF_EN) instructions loaded into IF/ID
//   KillCount    (FETCH_PERF_EN) responses / buffered words thrown away
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] KillCount
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // REQ : request PCF, waiting for the ack
    // WAIT: request accepted, waiting for the response
    // HOLD: response captured in the hold buffer because the pipe was stalled
    // KILL: a response is still in flight but its address was redirected away
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instrd_q, instrd_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;
    logic        validd_q, validd_d;

    logic [31:0] pcf_plus4;
    logic        go;            // both stall inputs low: the word may move on
    logic        deliver;       // an instruction is handed to IF/ID this cycle
    logic [31:0] deliver_instr;

    assign pcf_plus4 = pcf_q + 32'd4;   // wraps modulo 2^32
    assign go        = !StallF && !StallD;

    // ---------------------------------------------------------------------
    // Fetch FSM: next state, next PC and the hold buffer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        hold_d        = hold_q;
        deliver       = 1'b0;
        deliver_instr = hold_q;

        case (state_q)
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                    // An accepted request now fetches a stale address.
                    if (imem_ack) state_d = S_KILL;
                end else if (imem_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    if (go) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        pcf_d         = pcf_plus4;
                        state_d       = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = S_REQ;
                end else if (go) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_q;
                    pcf_d         = pcf_plus4;
                    state_d       = S_REQ;
                end
            end
            S_KILL: begin
                if (PCSrcE) pcf_d = PCTargetE;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // ---------------------------------------------------------------------
    // IF/ID register: FlushD > StallD > load > bubble
    // ---------------------------------------------------------------------
    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        validd_d   = validd_q;

        if (FlushD) begin
            // PC fields keep their old value so the flushed slot is deterministic.
            instrd_d = NOP;
            validd_d = 1'b0;
        end else if (StallD) begin
            // hold everything
        end else if (deliver) begin
            instrd_d   = deliver_instr;
            pcd_d      = pcf_q;
            pcplus4d_d = pcf_plus4;
            validd_d   = 1'b1;
        end else begin
            instrd_d = NOP;
            validd_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            pcf_q      <= RESET_PC;
            hold_q     <= '0;
            instrd_q   <= NOP;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            validd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            hold_q     <= hold_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            validd_q   <= validd_d;
        end
    end

    // The request is gated by reset_n so memory never sees a request while
    // the core is held in reset.
    assign imem_req  = reset_n && (state_q == S_REQ);
    assign imem_addr = pcf_q;

    assign InstrD   = instrd_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4d_q;
    assign ValidD   = validd_q;

`ifdef FETCH_PERF_EN
    // ---------------------------------------------------------------------
    // Performance counters
    // ---------------------------------------------------------------------
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;
    logic        fetch_evt;
    logic        kill_evt;

    // A delivered word only counts if the flush did not swallow it.
    assign fetch_evt = deliver && !FlushD;
    assign kill_evt  = ((state_q == S_KILL) && imem_rvalid) ||
                       ((state_q == S_WAIT) && imem_rvalid && PCSrcE) ||
                       ((state_q == S_HOLD) && PCSrcE);

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (fetch_evt) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (kill_evt)  kill_cnt_d  = kill_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign KillCount  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model tracks the fetch
// unit as a few flags (request outstanding, outstanding response doomed,
// buffered word present) plus the IF/ID contents; a small memory model answers
// requests with addr ^ 32'hA5A5_0000 after a configurable latency. Directed
// scenarios are followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XORK   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount, KillCount;
`endif

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount),
        .KillCount  (KillCount)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Behavioural model of the fetch unit
    logic [31:0] m_pc;
    logic        m_busy;      // a request was accepted and its response is pending
    logic        m_discard;   // the pending response belongs to a dead path
    logic        m_bufv;      // a word is parked waiting for the stall to clear
    logic [31:0] m_buf;
    logic [31:0] m_instr, m_pcd, m_pc4;
    logic        m_valid;
    logic [31:0] m_fetches, m_kills;

    // Memory model
    int          ack_pct = 100;
    int          lat_min = 1;   // cycles from ack to rvalid
    int          lat_max = 1;
    logic        mem_pend;
    int          mem_wait;
    logic [31:0] mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_bufv    = 1'b0;
        m_buf     = '0;
        m_instr   = NOP;
        m_pcd     = '0;
        m_pc4     = '0;
        m_valid   = 1'b0;
        m_fetches = '0;
        m_kills   = '0;
        mem_pend  = 1'b0;
        mem_wait  = 0;
        mem_data  = '0;
    endtask

    // Hold reset for n edges (called just after an edge), then release.
    task automatic do_reset(input int n);
        reset_n     = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = '0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("req_in_reset", 32'(imem_req), 32'd0);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        model_reset();
        reset_n = 1'b1;
        #1;
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input logic sf, input logic sd, input logic fd,
                        input logic pcs, input logic [31:0] tgt);
        logic        req, ack, rv, go, deliver;
        logic [31:0] rd, dword, pc_old;

        req = !m_busy && !m_bufv;
        chk("imem_req", 32'(imem_req), 32'(req));
        if (req) chk("imem_addr", imem_addr, m_pc);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pc4);
        chk("ValidD", 32'(ValidD), 32'(m_valid));
`ifdef FETCH_PERF_EN
        chk("FetchCount", FetchCount, m_fetches);
        chk("KillCount", KillCount, m_kills);
`endif

        ack = req && ($urandom_range(99, 0) < ack_pct);
        rv  = mem_pend && (mem_wait == 0);
        rd  = rv ? mem_data : $urandom();

        StallF      = sf;
        StallD      = sd;
        FlushD      = fd;
        PCSrcE      = pcs;
        PCTargetE   = tgt;
        imem_ack    = ack;
        imem_rvalid = rv;
        imem_rdata  = rd;

        pc_old  = m_pc;
        go      = !sf && !sd;
        deliver = 1'b0;
        dword   = '0;
        if (req) begin
            if (ack) begin
                m_busy    = 1'b1;
                m_discard = pcs;
            end
            if (pcs) m_pc = tgt;
        end else if (m_busy) begin
            if (pcs) m_pc = tgt;
            if (rv) begin
                m_busy = 1'b0;
                if (m_discard || pcs) begin
                    m_kills = m_kills + 32'd1;
                end else if (go) begin
                    deliver = 1'b1;
                    dword   = rd;
                    m_pc    = pc_old + 32'd4;
                end else begin
                    m_bufv = 1'b1;
                    m_buf  = rd;
                end
                m_discard = 1'b0;
            end else if (pcs) begin
                m_discard = 1'b1;
            end
        end else begin
            if (pcs) begin
                m_bufv  = 1'b0;
                m_kills = m_kills + 32'd1;
                m_pc    = tgt;
            end else if (go) begin
                deliver = 1'b1;
                dword   = m_buf;
                m_bufv  = 1'b0;
                m_pc    = pc_old + 32'd4;
            end
        end

        if (fd) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (sd) begin
            // IF/ID held
        end else if (deliver) begin
            m_instr   = dword;
            m_pcd     = pc_old;
            m_pc4     = pc_old + 32'd4;
            m_valid   = 1'b1;
            m_fetches = m_fetches + 32'd1;
            $display("cycle %0d fetch pc=%08h instr=%08h", cyc, pc_old, dword);
        end else begin
            m_instr = NOP;
            m_valid = 1'b0;
        end

        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_wait--;
        if (ack) begin
            mem_pend = 1'b1;
            mem_wait = $urandom_range(lat_max, lat_min) - 1;
            mem_data = pc_old ^ XORK;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        sf, sd, fd, pcs;
        logic [31:0] tgt;

        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset state
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_instr", InstrD, NOP);
        chk("rst_valid", 32'(ValidD), 32'd0);

        // Zero-wait memory: one instruction every two cycles
        ack_pct = 100; lat_min = 1; lat_max = 1;
        idle(2);
        chk("first_valid", 32'(ValidD), 32'd1);
        chk("first_pcd", PCD, 32'h0000_1000);
        chk("first_pc4", PCPlus4D, 32'h0000_1004);
        chk("first_instr", InstrD, 32'hA5A5_1000);
        idle(2);
        chk("second_pcd", PCD, 32'h0000_1004);
        idle(2);
        chk("third_pcd", PCD, 32'h0000_1008);

        // Latency 3 with StallD for 4 cycles from rvalid: word parked in HOLD
        lat_min = 3; lat_max = 3;
        idle(3);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold_no_req", 32'(imem_req), 32'd0);
        idle(1);
        chk("hold_valid", 32'(ValidD), 32'd1);
        chk("hold_instr", InstrD, 32'hA5A5_100C);
        chk("hold_pcd", PCD, 32'h0000_100C);

        // Redirect while in WAIT: the late response is dropped
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
        idle(2);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_2000);
        chk("redir_valid", 32'(ValidD), 32'd0);

        // FlushD together with StallD
        lat_min = 1; lat_max = 1;
        idle(2);
        chk("pre_flush_valid", 32'(ValidD), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_instr", InstrD, NOP);
        chk("flush_valid", 32'(ValidD), 32'd0);

        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        idle(2);
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while in KILL
        lat_min = 4; lat_max = 4;
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3000);
        do_reset(1);
        chk("kill_rst_addr", imem_addr, RST_PC);
        chk("kill_rst_req", 32'(imem_req), 32'd1);
        chk("kill_rst_instr", InstrD, NOP);
        chk("kill_rst_pcd", PCD, 32'h0);
        chk("kill_rst_pc4", PCPlus4D, 32'h0);
        chk("kill_rst_valid", 32'(ValidD), 32'd0);

        // Randomized run
        for (int blk = 0; blk < 8; blk++) begin
            ack_pct = 30 + 10 * blk;
            lat_min = 1;
            lat_max = 1 + (blk % 4);
            for (int i = 0; i < 400; i++) begin
                sf  = ($urandom_range(99, 0) < 20);
                sd  = ($urandom_range(99, 0) < 20);
                pcs = ($urandom_range(99, 0) < 8);
                fd  = pcs || ($urandom_range(99, 0) < 5);
                tgt = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
                if ($urandom_range(199, 0) == 0) do_reset(1);
                else step(sf, sd, fd, pcs, tgt);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
